// File: rtl/timer_core_param.sv
// timer_core_param: parametrised up/down timer core.
// A 4-bit prescaler produces a count-enable strobe every 2, 4, 8 or 16 clocks.
// A WIDTH-bit loadable counter steps up or down on that strobe. Sticky
// overflow/underflow flags are set on the wrapping edge and cleared by writing 1.
// Optional feature macro: TIMER_IRQ_EN builds the registered interrupt request.
// When the macro is absent, irq is tied low and irq_en is ignored.
module timer_core_param #(
  parameter int WIDTH = 8
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [7:0]       tcr,
  input  logic [WIDTH-1:0] tdr,
  input  logic [1:0]       sts_clr,
  input  logic [1:0]       irq_en,
  output logic [WIDTH-1:0] cnt,
  output logic             tick,
  output logic             ovf_flag,
  output logic             udf_flag,
  output logic             irq
);

  logic       load;
  logic       down;
  logic       enable;
  logic [3:0] div;
  logic [3:0] mask;
  logic       wrap_up;
  logic       wrap_down;

  assign load   = tcr[7];
  assign down   = tcr[5];
  assign enable = tcr[4];

  // Unused control bits are reserved in TCR.
  logic unused_tcr;
  assign unused_tcr = ^{tcr[6], tcr[3:2]};

  // Select the prescaler match mask from the clock-select field.
  always_comb begin
    mask = 4'h1;
    unique case (tcr[1:0])
      2'd0: mask = 4'h1;
      2'd1: mask = 4'h3;
      2'd2: mask = 4'h7;
      2'd3: mask = 4'hF;
      default: mask = 4'h1;
    endcase
  end

  // The prescaler free-runs while enabled and restarts its phase on load or disable.
  always_ff @(posedge PCLK) begin
    if (PRESET || !enable || load) begin
      div <= 4'h0;
    end else begin
      div <= div + 4'h1;
    end
  end

  // The strobe fires when the low prescaler bits selected by the mask are all set.
  assign tick = enable & ~load & ((div & mask) == mask);

  // A wrap occurs on a tick that steps past all-ones (up) or below zero (down).
  assign wrap_up   = tick & ~down & (cnt == {WIDTH{1'b1}});
  assign wrap_down = tick &  down & (cnt == {WIDTH{1'b0}});

  // The counter honours this priority: reset, then load, then tick, then hold.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= tdr;
    end else if (tick) begin
      if (down) begin
        cnt <= cnt - WIDTH'(1);
      end else begin
        cnt <= cnt + WIDTH'(1);
      end
    end
  end

  // Sticky flags: a set on a wrapping edge beats a simultaneous write-1-to-clear.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ovf_flag <= 1'b0;
      udf_flag <= 1'b0;
    end else begin
      if (wrap_up) begin
        ovf_flag <= 1'b1;
      end else if (sts_clr[0]) begin
        ovf_flag <= 1'b0;
      end
      if (wrap_down) begin
        udf_flag <= 1'b1;
      end else if (sts_clr[1]) begin
        udf_flag <= 1'b0;
      end
    end
  end

`ifdef TIMER_IRQ_EN
  // The interrupt request is registered from the enabled flags, one cycle behind them.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      irq <= 1'b0;
    end else begin
      irq <= (ovf_flag & irq_en[0]) | (udf_flag & irq_en[1]);
    end
  end
`else
  // Without the interrupt feature the request is held low and the enables are ignored.
  logic unused_irq_en;
  assign unused_irq_en = ^irq_en;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_timer_core_param.sv
// tb_timer_core_param: randomized plus directed bench for timer_core_param.
// It drives an 8-bit and a 12-bit instance from shared controls. Both instances
// are compared every cycle against a behavioural model. The model counts clocks
// since enable and uses modular arithmetic on the count values.
module tb_timer_core_param;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [7:0]  tcr;
  logic [7:0]  tdr8;
  logic [11:0] tdr12;
  logic [1:0]  sts_clr;
  logic [1:0]  irq_en;

  logic [7:0]  cnt8;
  logic [11:0] cnt12;
  logic        tick8, tick12, ovf8, ovf12, udf8, udf12, irq8, irq12;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int cycle  = 0;

  // Behavioural model state: clocks since the prescaler restarted (mod 16), plus per-instance values.
  int          m_div;
  int unsigned m_cnt [2];
  bit          m_ovf [2];
  bit          m_udf [2];
  bit          m_irq [2];
  int          wid   [2] = '{8, 12};

  timer_core_param #(.WIDTH(8)) dut8 (
    .PCLK(PCLK), .PRESET(PRESET), .tcr(tcr), .tdr(tdr8), .sts_clr(sts_clr),
    .irq_en(irq_en), .cnt(cnt8), .tick(tick8), .ovf_flag(ovf8),
    .udf_flag(udf8), .irq(irq8)
  );

  timer_core_param #(.WIDTH(12)) dut12 (
    .PCLK(PCLK), .PRESET(PRESET), .tcr(tcr), .tdr(tdr12), .sts_clr(sts_clr),
    .irq_en(irq_en), .cnt(cnt12), .tick(tick12), .ovf_flag(ovf12),
    .udf_flag(udf12), .irq(irq12)
  );

  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s cycle %0d: observed %0h expected %0h", tag, cycle, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check the strobe, advance one edge, update the model and check the outputs.
  task automatic applyStimulus(input logic rst, input logic [7:0] ctl, input logic [7:0] d8,
                               input logic [11:0] d12, input logic [1:0] clr, input logic [1:0] ien);
    bit          t;
    int          period;
    int          n_div;
    int unsigned maxv, n_cnt [2];
    bit          n_ovf [2], n_udf [2], n_irq [2];
    bit          set_o, set_u;
    PRESET = rst; tcr = ctl; tdr8 = d8; tdr12 = d12; sts_clr = clr; irq_en = ien;
    #2;
    period = 2 << ctl[1:0];
    t = ctl[4] && !ctl[7] && (((m_div + 1) % period) == 0);
    checkOutput("tick8", {31'd0, tick8}, {31'd0, t});
    checkOutput("tick12", {31'd0, tick12}, {31'd0, t});
    n_div = (ctl[4] && !ctl[7] && !rst) ? (m_div + 1) % 16 : 0;
    for (int k = 0; k < 2; k++) begin
      maxv = (32'd1 << wid[k]) - 1;
      set_o = 0; set_u = 0;
      n_cnt[k] = m_cnt[k];
      if (ctl[7]) begin
        n_cnt[k] = ((k == 0) ? {24'd0, d8} : {20'd0, d12}) & maxv;
      end else if (t) begin
        if (ctl[5]) begin
          set_u = (m_cnt[k] == 0);
          n_cnt[k] = set_u ? maxv : m_cnt[k] - 1;
        end else begin
          set_o = (m_cnt[k] == maxv);
          n_cnt[k] = set_o ? 0 : m_cnt[k] + 1;
        end
      end
      n_ovf[k] = set_o ? 1'b1 : (clr[0] ? 1'b0 : m_ovf[k]);
      n_udf[k] = set_u ? 1'b1 : (clr[1] ? 1'b0 : m_udf[k]);
`ifdef TIMER_IRQ_EN
      n_irq[k] = (m_ovf[k] && ien[0]) || (m_udf[k] && ien[1]);
`else
      n_irq[k] = 1'b0;
`endif
      if (rst) begin
        n_cnt[k] = 0; n_ovf[k] = 0; n_udf[k] = 0; n_irq[k] = 0;
      end
    end
    @(posedge PCLK);
    #1;
    cycle++;
    m_div = n_div;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = n_cnt[k]; m_ovf[k] = n_ovf[k]; m_udf[k] = n_udf[k]; m_irq[k] = n_irq[k];
    end
    checkOutput("cnt8", {24'd0, cnt8}, m_cnt[0]);
    checkOutput("cnt12", {20'd0, cnt12}, m_cnt[1]);
    checkOutput("ovf8", {31'd0, ovf8}, {31'd0, m_ovf[0]});
    checkOutput("ovf12", {31'd0, ovf12}, {31'd0, m_ovf[1]});
    checkOutput("udf8", {31'd0, udf8}, {31'd0, m_udf[0]});
    checkOutput("udf12", {31'd0, udf12}, {31'd0, m_udf[1]});
    checkOutput("irq8", {31'd0, irq8}, {31'd0, m_irq[0]});
    checkOutput("irq12", {31'd0, irq12}, {31'd0, m_irq[1]});
  endtask

  // Directed scenarios first, then a randomized run, then the summary.
  initial begin
    logic [7:0]  r_tcr;
    logic [1:0]  r_ien;
    logic [31:0] r;
    int          pick;

    PRESET = 1'b1; tcr = 8'h10; tdr8 = 8'h00; tdr12 = 12'h000; sts_clr = 2'b00; irq_en = 2'b00;
    @(posedge PCLK);
    #1;
    m_div = 0;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_ovf[k] = 0; m_udf[k] = 0; m_irq[k] = 0;
    end
    checkOutput("reset_cnt8", {24'd0, cnt8}, 32'd0);
    checkOutput("reset_irq8", {31'd0, irq8}, 32'd0);
    applyStimulus(1'b1, 8'h10, 8'h00, 12'h000, 2'b00, 2'b00);

    // Load FE / FFF, then count up at /2; collide a clear with the 8-bit wrap.
    applyStimulus(1'b0, 8'h80, 8'hFE, 12'hFFF, 2'b00, 2'b10);
    applyStimulus(1'b0, 8'h10, 8'hFE, 12'hFFF, 2'b00, 2'b10);
    applyStimulus(1'b0, 8'h10, 8'hFE, 12'hFFF, 2'b00, 2'b10);
    applyStimulus(1'b0, 8'h10, 8'hFE, 12'hFFF, 2'b00, 2'b10);
    applyStimulus(1'b0, 8'h10, 8'hFE, 12'hFFF, 2'b01, 2'b10);
    checkOutput("collide_ovf8", {31'd0, ovf8}, 32'd1);
    applyStimulus(1'b0, 8'h10, 8'hFE, 12'hFFF, 2'b00, 2'b10);
    checkOutput("irq_masked_ovf", {31'd0, irq8}, 32'd0);
    applyStimulus(1'b0, 8'h10, 8'hFE, 12'hFFF, 2'b01, 2'b10);
    checkOutput("late_clear_ovf8", {31'd0, ovf8}, 32'd0);

    // Load 01 and count down at /16 through the underflow, then clear it.
    applyStimulus(1'b0, 8'h80, 8'h01, 12'h001, 2'b00, 2'b10);
    for (int i = 0; i < 34; i++) applyStimulus(1'b0, 8'h33, 8'h01, 12'h001, 2'b00, 2'b10);
    checkOutput("udf8_after_wrap", {31'd0, udf8}, 32'd1);
    checkOutput("cnt8_after_wrap", {24'd0, cnt8}, 32'hFF);
    applyStimulus(1'b0, 8'h33, 8'h01, 12'h001, 2'b10, 2'b10);
    applyStimulus(1'b0, 8'h33, 8'h01, 12'h001, 2'b00, 2'b10);

    // Load with enable also set must hold tdr without ticking.
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h90, 8'h5A, 12'hA5C, 2'b00, 2'b11);
    checkOutput("load_hold12", {20'd0, cnt12}, 32'hA5C);

    // 12-bit wrap counting up at /4 from FFF.
    applyStimulus(1'b0, 8'h80, 8'hFF, 12'hFFF, 2'b11, 2'b11);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h11, 8'hFF, 12'hFFF, 2'b00, 2'b11);

    // Reset in the middle of a count, then resume.
    applyStimulus(1'b1, 8'h10, 8'h00, 12'h000, 2'b00, 2'b11);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h10, 8'h00, 12'h000, 2'b00, 2'b11);

    // Randomized run with sticky direction/prescaler choices and values biased to the extremes.
    r_tcr = 8'h10; r_ien = 2'b11;
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      if ($urandom_range(0, 29) == 0) r_tcr[1:0] = r[1:0];
      if ($urandom_range(0, 39) == 0) r_tcr[5] = ~r_tcr[5];
      r_tcr[4] = ($urandom_range(0, 9) != 0);
      r_tcr[7] = ($urandom_range(0, 24) == 0);
      r_tcr[6] = r[6]; r_tcr[3:2] = r[3:2];
      if ($urandom_range(0, 19) == 0) r_ien = r[9:8];
      pick = $urandom_range(0, 3);
      case (pick)
        0: begin tdr8 = 8'h00; tdr12 = 12'h000; end
        1: begin tdr8 = 8'hFF; tdr12 = 12'hFFF; end
        2: begin tdr8 = 8'hFE; tdr12 = 12'h001; end
        default: begin tdr8 = r[23:16]; tdr12 = r[31:20]; end
      endcase
      applyStimulus(($urandom_range(0, 149) == 0), r_tcr, tdr8, tdr12,
                    (($urandom_range(0, 7) == 0) ? r[11:10] : 2'b00), r_ien);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
